// File: rtl/song_timer.sv
// Elapsed mm:ss timer for the seven-segment display stage; presents mm*100+ss with a write strobe.
// Optional count-down mode is enabled by defining SONG_TIMER_COUNTDOWN_EN.
module song_timer #(
    parameter int CLK_HZ          = 100000000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clock_100Mhz,
    input  logic        reset_n,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
`ifdef SONG_TIMER_COUNTDOWN_EN
    input  logic [6:0]  preset_min,
    input  logic [5:0]  preset_sec,
    output logic        done,
`endif
    output logic [15:0] displayed_number,
    output logic        we,
    output logic        running,
    output logic        at_max
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(DIV - 1);
    localparam logic [DW-1:0] DEB_TC   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, MAXED} state_t;

    // Button conditioning: index 0 = start/stop, index 1 = clear.
    logic [1:0]         btn_raw;
    logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]         deb_q, deb_d, press_q, press_d;
    logic [1:0][DW-1:0] cnt_q, cnt_d;

    state_t        state_q, state_d;
    logic [6:0]    min_q, min_d, load_min;
    logic [5:0]    sec_q, sec_d, load_sec;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   disp_q, disp_d;
    logic          we_q, upd;
    logic          running_q, at_max_q;
    logic          first_q;
    logic          tick, start_press, clear_press;
`ifdef SONG_TIMER_COUNTDOWN_EN
    logic          done_q, done_d;
`endif

    assign btn_raw     = {btn_clear, btn_start_stop};
    assign start_press = press_q[0];
    assign clear_press = press_q[1];
    assign tick        = (state_q == RUN) && (presc_q == PRESC_TC);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        press_d = '0;
        cnt_d   = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_TC) begin
                    deb_d[i]   = sync2_q[i];
                    press_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DW'(1);
                end
            end
        end
    end

`ifdef SONG_TIMER_COUNTDOWN_EN
    assign load_min = (preset_min > 7'd99) ? 7'd99 : preset_min;
    assign load_sec = (preset_sec > 6'd59) ? 6'd59 : preset_sec;
`else
    assign load_min = '0;
    assign load_sec = '0;
`endif

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        presc_d = presc_q;
        upd     = 1'b0;
`ifdef SONG_TIMER_COUNTDOWN_EN
        done_d  = 1'b0;
`endif
        if (first_q) begin
            min_d = load_min;
            sec_d = load_sec;
            upd   = 1'b1;
        end else if (clear_press) begin
            // Clear outranks a simultaneous start press or tick.
            state_d = IDLE;
            min_d   = load_min;
            sec_d   = load_sec;
            presc_d = '0;
            upd     = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    presc_d = '0;
                    if (start_press) state_d = RUN;
                end
                RUN: begin
                    if (start_press) state_d = PAUSE;
                    if (!tick) begin
                        presc_d = presc_q + PW'(1);
                    end else begin
                        presc_d = '0;
`ifdef SONG_TIMER_COUNTDOWN_EN
                        if (min_q == 7'd0 && sec_q <= 6'd1) begin
                            min_d   = '0;
                            sec_d   = '0;
                            state_d = MAXED;
                            done_d  = 1'b1;
                            upd     = (sec_q != 6'd0);
                        end else begin
                            upd = 1'b1;
                            if (sec_q == 6'd0) begin
                                sec_d = 6'd59;
                                min_d = min_q - 7'd1;
                            end else begin
                                sec_d = sec_q - 6'd1;
                            end
                        end
`else
                        if (min_q == 7'd99 && sec_q == 6'd59) begin
                            state_d = MAXED;
                        end else begin
                            upd = 1'b1;
                            if (sec_q == 6'd59) begin
                                sec_d = '0;
                                min_d = min_q + 7'd1;
                            end else begin
                                sec_d = sec_q + 6'd1;
                            end
                        end
`endif
                    end
                end
                PAUSE: begin
                    if (start_press) state_d = RUN;
                end
                MAXED: begin
                    presc_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
        disp_d = 16'(min_d) * 16'd100 + 16'(sec_d);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            press_q   <= '0;
            cnt_q     <= '0;
            state_q   <= IDLE;
            min_q     <= '0;
            sec_q     <= '0;
            presc_q   <= '0;
            disp_q    <= '0;
            we_q      <= 1'b0;
            running_q <= 1'b0;
            at_max_q  <= 1'b0;
            first_q   <= 1'b1;
`ifdef SONG_TIMER_COUNTDOWN_EN
            done_q    <= 1'b0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            press_q   <= press_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            presc_q   <= presc_d;
            disp_q    <= disp_d;
            we_q      <= upd;
            running_q <= (state_d == RUN);
            at_max_q  <= (state_d == MAXED);
            first_q   <= 1'b0;
`ifdef SONG_TIMER_COUNTDOWN_EN
            done_q    <= done_d;
`endif
        end
    end

    assign displayed_number = disp_q;
    assign we               = we_q;
    assign running          = running_q;
    assign at_max           = at_max_q;
`ifdef SONG_TIMER_COUNTDOWN_EN
    assign done             = done_q;
`endif

endmodule
